// File: rtl/mm_bram_arbiter_if.sv
// rtl/mm_bram_arbiter_if.sv - requester and BRAM-side signal bundle for mm_bram_arbiter
interface mm_bram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 17
);
  logic [1:0]              req_i;
  logic [1:0]              en_i;
  logic [1:0]              we_i;
  logic [2*ADDR_WIDTH-1:0] addr_i;
  logic [2*DATA_WIDTH-1:0] din_i;
  logic [1:0]              gnt_o;
  logic [1:0]              rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    BRAM_en_o;
  logic                    BRAM_we_o;
  logic [ADDR_WIDTH-1:0]   BRAM_addr_o;
  logic [DATA_WIDTH-1:0]   BRAM_din_o;
  logic [DATA_WIDTH-1:0]   BRAM_dout_i;

  modport slave (
    input  req_i, en_i, we_i, addr_i, din_i, BRAM_dout_i,
    output gnt_o, rvalid_o, rdata_o, BRAM_en_o, BRAM_we_o, BRAM_addr_o, BRAM_din_o
  );

  modport master (
    output req_i, en_i, we_i, addr_i, din_i, BRAM_dout_i,
    input  gnt_o, rvalid_o, rdata_o, BRAM_en_o, BRAM_we_o, BRAM_addr_o, BRAM_din_o
  );
endinterface

// File: rtl/mm_bram_arbiter.sv
// rtl/mm_bram_arbiter.sv - two-requester BRAM port arbiter with round-robin tie-break and read-valid routing
// Optional preemption after HOLD_LIMIT contested cycles when MM_ARB_HOLD_LIMIT_EN is defined.
module mm_bram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 17,
  parameter int HOLD_LIMIT = 64
) (
  input logic           clock_i,
  input logic           reset_i,
  mm_bram_arbiter_if.slave bus
);
  // State value doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_owner;
  logic   w_next_last;
  logic [1:0] r_rd_tag;
  logic   w_sel;
  logic   w_own_req;
  logic   w_oth_req;
  state_t w_other_state;

  logic                  w_bram_en;
  logic                  w_bram_we;
  logic [ADDR_WIDTH-1:0] w_bram_addr;
  logic [DATA_WIDTH-1:0] w_bram_din;

  assign w_sel         = (r_state == OWN1);
  assign w_own_req     = bus.req_i[w_sel];
  assign w_oth_req     = bus.req_i[~w_sel];
  assign w_other_state = w_sel ? OWN0 : OWN1;

`ifdef MM_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_LIMIT) + 1;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             w_hold_expired;

  assign w_hold_expired = w_oth_req && (r_hold_cnt == CNT_W'(HOLD_LIMIT - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_hold_cnt <= '0;
    end else if (w_next != r_state) begin
      r_hold_cnt <= '0;
    end else if (r_state != IDLE && w_oth_req) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`else
  logic w_hold_expired;
  logic w_unused_hold_limit;

  assign w_hold_expired      = 1'b0;
  assign w_unused_hold_limit = ^HOLD_LIMIT;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_rd_tag     <= 2'b00;
    end else begin
      r_state      <= w_next;
      r_last_owner <= w_next_last;
      r_rd_tag     <= (w_bram_en && !w_bram_we) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_next_last = r_last_owner;
    case (r_state)
      IDLE: begin
        case (bus.req_i)
          2'b01:   w_next = OWN0;
          2'b10:   w_next = OWN1;
          2'b11:   w_next = r_last_owner ? OWN0 : OWN1;
          default: w_next = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (!w_own_req) begin
          w_next      = w_oth_req ? w_other_state : IDLE;
          w_next_last = w_sel;
        end else if (w_hold_expired) begin
          w_next      = w_other_state;
          w_next_last = w_sel;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Only the owner reaches the port; a non-owner's strobes are simply dropped.
  always_comb begin
    w_bram_en   = 1'b0;
    w_bram_we   = 1'b0;
    w_bram_addr = '0;
    w_bram_din  = '0;
    if (r_state == OWN0 || r_state == OWN1) begin
      w_bram_en   = bus.en_i[w_sel] & w_own_req;
      w_bram_we   = bus.we_i[w_sel];
      w_bram_addr = w_sel ? bus.addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.addr_i[ADDR_WIDTH-1:0];
      w_bram_din  = w_sel ? bus.din_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.din_i[DATA_WIDTH-1:0];
    end
  end

  assign bus.gnt_o       = r_state;
  assign bus.rvalid_o    = r_rd_tag;
  assign bus.rdata_o     = bus.BRAM_dout_i;
  assign bus.BRAM_en_o   = w_bram_en;
  assign bus.BRAM_we_o   = w_bram_we;
  assign bus.BRAM_addr_o = w_bram_addr;
  assign bus.BRAM_din_o  = w_bram_din;
endmodule

// File: tb/tb_mm_bram_arbiter.sv
// tb/tb_mm_bram_arbiter.sv - self-checking bench for mm_bram_arbiter with a transaction-level model
module tb_mm_bram_arbiter;
  localparam int AW = 32;
  localparam int DW = 17;
  localparam int HL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mm_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mm_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_LIMIT(HL)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // BRAM behind the port: one-cycle registered read.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.BRAM_en_o) begin
      if (bus.BRAM_we_o) mem[bus.BRAM_addr_o[5:0]] <= bus.BRAM_din_o;
      else               bus.BRAM_dout_i <= mem[bus.BRAM_addr_o[5:0]];
    end
  end

  // Reference model: owner as an integer (-1 = nobody), memory as an array.
  int            m_owner;
  int            m_last;
  int            m_cnt;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [0:63];

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_rv    = 2'b00;
  endfunction

  function automatic void model_update();
    int nxt;
    int o;
    logic [1:0] r;
    logic [5:0] a;
    logic [DW-1:0] d;
    r    = bus.req_i;
    m_rv = 2'b00;
    if (m_owner >= 0 && bus.en_i[m_owner] && r[m_owner]) begin
      a = (m_owner == 1) ? bus.addr_i[AW+5:AW] : bus.addr_i[5:0];
      d = (m_owner == 1) ? bus.din_i[2*DW-1:DW] : bus.din_i[DW-1:0];
      if (bus.we_i[m_owner]) m_mem[a] = d;
      else begin
        m_rv    = (m_owner == 1) ? 2'b10 : 2'b01;
        m_rdata = m_mem[a];
      end
    end
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r == 2'b11)  nxt = 1 - m_last;
      else if (r[0])   nxt = 0;
      else if (r[1])   nxt = 1;
    end else begin
      o = m_owner;
      if (!r[o]) begin
        nxt    = r[1-o] ? 1 - o : -1;
        m_last = o;
      end
`ifdef MM_ARB_HOLD_LIMIT_EN
      else if (r[1-o]) begin
        if (m_cnt == HL - 1) begin
          nxt    = 1 - o;
          m_last = o;
        end else m_cnt++;
      end
`endif
    end
    if (nxt != m_owner) m_cnt = 0;
    m_owner = nxt;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] en, input logic [1:0] we,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req_i  = req;
    bus.en_i   = en;
    bus.we_i   = we;
    bus.addr_i = {AW'(a1), AW'(a0)};
    bus.din_i  = {d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b11, 2'b01, 6'd9, 6'd12, 17'h1FFFF, 17'h12345);
    @(posedge clk);
    #1;
    if (bus.gnt_o !== 2'b00 || bus.rvalid_o !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_regs gnt_o=%b rvalid_o=%b required 00/00", bus.gnt_o, bus.rvalid_o);
    end
    n_checks++;
    if ({bus.BRAM_en_o, bus.BRAM_we_o} !== 2'b00 || bus.BRAM_addr_o !== '0 || bus.BRAM_din_o !== '0) begin
      n_errors++;
      $display("FAIL reset_bram en=%b we=%b addr=%h din=%h required all 0",
               bus.BRAM_en_o, bus.BRAM_we_o, bus.BRAM_addr_o, bus.BRAM_din_o);
    end
    n_checks++;
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
      tick();
    end
    drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    if (bus.gnt_o !== 2'b00) begin
      n_errors++;
      $display("FAIL wr_pre_grant gnt_o=%b required 00", bus.gnt_o);
    end
    n_checks++;
    tick();
    if (bus.gnt_o !== 2'b01) begin
      n_errors++;
      $display("FAIL wr_grant gnt_o=%b required 01", bus.gnt_o);
    end
    n_checks++;
    drive(2'b01, 2'b01, 2'b01, 6'd5, 6'd0, 17'h1ABCD, '0);
    if (bus.BRAM_en_o !== 1'b1 || bus.BRAM_we_o !== 1'b1 || bus.BRAM_addr_o !== AW'(5) || bus.BRAM_din_o !== 17'h1ABCD) begin
      n_errors++;
      $display("FAIL wr_port en=%b we=%b addr=%h din=%h required 1/1/5/1abcd",
               bus.BRAM_en_o, bus.BRAM_we_o, bus.BRAM_addr_o, bus.BRAM_din_o);
    end
    n_checks++;
    tick();
    drive(2'b01, 2'b01, 2'b00, 6'd5, 6'd0, '0, '0);
    tick();
    if (bus.rvalid_o !== 2'b01 || bus.rdata_o !== 17'h1ABCD) begin
      n_errors++;
      $display("FAIL wr_readback rvalid_o=%b rdata_o=%h required 01/1abcd", bus.rvalid_o, bus.rdata_o);
    end
    n_checks++;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    if (bus.gnt_o !== 2'b00 || bus.rvalid_o !== 2'b00) begin
      n_errors++;
      $display("FAIL wr_release gnt_o=%b rvalid_o=%b required 00/00", bus.gnt_o, bus.rvalid_o);
    end
    n_checks++;
  endtask

  task automatic test_round_robin();
    logic [1:0] reqs [0:6];
    logic [1:0] gnts [0:6];
    reqs = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
    gnts = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(reqs[i], 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
      tick();
      if (bus.gnt_o !== gnts[i]) begin
        n_errors++;
        $display("FAIL rr_step%0d gnt_o=%b required %b", i, bus.gnt_o, gnts[i]);
      end
      n_checks++;
    end
    drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    if (bus.gnt_o !== 2'b10) begin
      n_errors++;
      $display("FAIL rr_alternate gnt_o=%b required 10", bus.gnt_o);
    end
    n_checks++;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
  endtask

  task automatic test_last_cycle_read();
    do_reset();
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    drive(2'b10, 2'b10, 2'b10, 6'd0, 6'd7, '0, 17'h0F00D);
    tick();
    drive(2'b11, 2'b10, 2'b00, 6'd0, 6'd7, '0, '0);
    tick();
    drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    if (bus.rvalid_o !== 2'b10 || bus.rdata_o !== 17'h0F00D || bus.gnt_o !== 2'b10) begin
      n_errors++;
      $display("FAIL last_read rvalid_o=%b rdata_o=%h gnt_o=%b required 10/0f00d/10",
               bus.rvalid_o, bus.rdata_o, bus.gnt_o);
    end
    n_checks++;
    tick();
    if (bus.gnt_o !== 2'b01 || bus.rvalid_o !== 2'b00) begin
      n_errors++;
      $display("FAIL last_handover gnt_o=%b rvalid_o=%b required 01/00", bus.gnt_o, bus.rvalid_o);
    end
    n_checks++;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
  endtask

  task automatic test_nonowner();
    do_reset();
    drive(2'b01, 2'b11, 2'b11, 6'd3, 6'd3, 17'h15A5A, 17'h00BAD);
    if (bus.BRAM_en_o !== 1'b0) begin
      n_errors++;
      $display("FAIL pregrant_drop BRAM_en_o=%b required 0", bus.BRAM_en_o);
    end
    n_checks++;
    tick();
    drive(2'b01, 2'b01, 2'b01, 6'd3, 6'd0, 17'h15A5A, '0);
    tick();
    drive(2'b11, 2'b11, 2'b10, 6'd3, 6'd3, 17'h15A5A, 17'h00BAD);
    if (bus.BRAM_en_o !== 1'b1 || bus.BRAM_we_o !== 1'b0 || bus.BRAM_addr_o !== AW'(3) || bus.BRAM_din_o !== 17'h15A5A) begin
      n_errors++;
      $display("FAIL nonowner_mux en=%b we=%b addr=%h din=%h required 1/0/3/15a5a",
               bus.BRAM_en_o, bus.BRAM_we_o, bus.BRAM_addr_o, bus.BRAM_din_o);
    end
    n_checks++;
    tick();
    drive(2'b11, 2'b10, 2'b10, 6'd0, 6'd3, '0, 17'h00BAD);
    if (bus.rvalid_o !== 2'b01 || bus.rdata_o !== 17'h15A5A || bus.BRAM_en_o !== 1'b0) begin
      n_errors++;
      $display("FAIL nonowner_ignore rvalid_o=%b rdata_o=%h BRAM_en_o=%b required 01/15a5a/0",
               bus.rvalid_o, bus.rdata_o, bus.BRAM_en_o);
    end
    n_checks++;
    tick();
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    drive(2'b10, 2'b10, 2'b00, 6'd0, 6'd3, '0, '0);
    tick();
    if (bus.rvalid_o !== 2'b10 || bus.rdata_o !== 17'h15A5A) begin
      n_errors++;
      $display("FAIL nonowner_nocorrupt rvalid_o=%b rdata_o=%h required 10/15a5a", bus.rvalid_o, bus.rdata_o);
    end
    n_checks++;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
  endtask

  task automatic test_hold();
    int held;
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
`ifdef MM_ARB_HOLD_LIMIT_EN
    held = 0;
    for (int i = 0; i < HL; i++) begin
      drive(2'b11, (i == HL - 1) ? 2'b01 : 2'b00, 2'b00, 6'd5, 6'd0, '0, '0);
      if (bus.gnt_o == 2'b01) held++;
      tick();
    end
    if (held != HL || bus.gnt_o !== 2'b10 || bus.rvalid_o !== 2'b01 || bus.rdata_o !== 17'h1ABCD) begin
      n_errors++;
      $display("FAIL hold_preempt held=%0d gnt_o=%b rvalid_o=%b rdata_o=%h required %0d/10/01/1abcd",
               held, bus.gnt_o, bus.rvalid_o, bus.rdata_o, HL);
    end
    n_checks++;
    for (int i = 0; i < HL; i++) begin
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
      tick();
    end
    if (bus.gnt_o !== 2'b01) begin
      n_errors++;
      $display("FAIL hold_regrant gnt_o=%b required 01", bus.gnt_o);
    end
    n_checks++;
`else
    held = 0;
    for (int i = 0; i < 120; i++) begin
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
      tick();
      if (bus.gnt_o == 2'b01) held++;
    end
    if (held != 120) begin
      n_errors++;
      $display("FAIL hold_none cycles_owned=%0d required 120", held);
    end
    n_checks++;
`endif
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    drive(2'b01, 2'b01, 2'b00, 6'd5, 6'd0, '0, '0);
    tick();
    if (bus.rvalid_o !== 2'b01) begin
      n_errors++;
      $display("FAIL rmid_pre rvalid_o=%b required 01", bus.rvalid_o);
    end
    n_checks++;
    rst = 1'b1;
    #1;
    if (bus.rvalid_o !== 2'b00 || bus.gnt_o !== 2'b00 || bus.BRAM_en_o !== 1'b0 || bus.BRAM_addr_o !== '0) begin
      n_errors++;
      $display("FAIL rmid_async rvalid_o=%b gnt_o=%b en=%b addr=%h required 00/00/0/0",
               bus.rvalid_o, bus.gnt_o, bus.BRAM_en_o, bus.BRAM_addr_o);
    end
    n_checks++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, '0, '0);
    tick();
    drive(2'b01, 2'b01, 2'b00, 6'd5, 6'd0, '0, '0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (bus.rvalid_o !== 2'b00) begin
      n_errors++;
      $display("FAIL rmid_pending rvalid_o=%b required 00", bus.rvalid_o);
    end
    n_checks++;
    do_reset();
    tick();
    if (bus.rvalid_o !== 2'b00 || bus.gnt_o !== 2'b00) begin
      n_errors++;
      $display("FAIL rmid_after rvalid_o=%b gnt_o=%b required 00/00", bus.rvalid_o, bus.gnt_o);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [1:0] en;
    logic [1:0] we;
    logic [5:0] a0;
    logic [5:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic e_en;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    int errs;
    do_reset();
    req  = 2'b00;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req[0] = ~req[0];
      if ($urandom_range(3) == 0) req[1] = ~req[1];
      en = 2'($urandom);
      we = 2'($urandom);
      a0 = 6'($urandom_range(7));
      a1 = 6'($urandom_range(7));
      d0 = DW'($urandom);
      d1 = DW'($urandom);
      drive(req, en, we, a0, a1, d0, d1);
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
      if (m_owner == 0) begin
        e_en = en[0] & req[0]; e_we = we[0]; e_addr = AW'(a0); e_din = d0;
      end else if (m_owner == 1) begin
        e_en = en[1] & req[1]; e_we = we[1]; e_addr = AW'(a1); e_din = d1;
      end
      if (bus.gnt_o !== ((m_owner < 0) ? 2'b00 : (m_owner == 0) ? 2'b01 : 2'b10)) begin
        n_errors++; errs++;
        if (errs < 10) $display("FAIL rnd_gnt cycle=%0d gnt_o=%b required owner %0d", i, bus.gnt_o, m_owner);
      end
      n_checks++;
      if (bus.rvalid_o !== m_rv || (m_rv != 2'b00 && bus.rdata_o !== m_rdata)) begin
        n_errors++; errs++;
        if (errs < 10) $display("FAIL rnd_read cycle=%0d rvalid_o=%b rdata_o=%h required %b/%h",
                                i, bus.rvalid_o, bus.rdata_o, m_rv, m_rdata);
      end
      n_checks++;
      if (bus.BRAM_en_o !== e_en || bus.BRAM_we_o !== e_we || bus.BRAM_addr_o !== e_addr || bus.BRAM_din_o !== e_din) begin
        n_errors++; errs++;
        if (errs < 10) $display("FAIL rnd_port cycle=%0d en=%b we=%b addr=%h din=%h required %b/%b/%h/%h",
                                i, bus.BRAM_en_o, bus.BRAM_we_o, bus.BRAM_addr_o, bus.BRAM_din_o,
                                e_en, e_we, e_addr, e_din);
      end
      n_checks++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
    bus.BRAM_dout_i = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_round_robin();
    test_last_cycle_read();
    test_nonowner();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
